// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the external interrupt controller.
// Contents:
//   irq_state_e    controller states IRQ_IDLE / IRQ_REQ / IRQ_SERV
//   IRQ_ADDR_*     config register addresses (MASK, PEND, CAUSE, TCMP)
//   IRQ_ID_NONE    irq_id value when no source is being serviced
//   irq_first()    index of the lowest set bit, IRQ_ID_NONE when empty
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SERV = 2'd2
  } irq_state_e;

  localparam logic [1:0] IRQ_ADDR_MASK  = 2'd0;
  localparam logic [1:0] IRQ_ADDR_PEND  = 2'd1;
  localparam logic [1:0] IRQ_ADDR_CAUSE = 2'd2;
  localparam logic [1:0] IRQ_ADDR_TCMP  = 2'd3;

  localparam logic [3:0] IRQ_ID_NONE = 4'hF;

  // Fixed priority: the lowest set index wins.
  function automatic logic [3:0] irq_first(input logic [15:0] vec);
    logic [3:0] idx;
    idx = IRQ_ID_NONE;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Bus bundle between the interrupt controller, its request lines, the
// config port and the core's interrupt handshake.
// Signals:
//   irq_in[N_SRC]  raw asynchronous request lines
//   cfg_wen/cfg_addr/cfg_din/cfg_dout  config register access
//   interrupter    request to the core
//   ir_ack/ir_ret  core took the interrupt / handler returned (ERET)
//   irq_id         serviced source index, 4'hF when none
//   busy           handler in progress
// Modports: slave = controller side, master = core/config side.
interface irq_ctrl_if #(
  parameter int N_SRC = 4
) ();
  logic [N_SRC-1:0] irq_in;
  logic             cfg_wen;
  logic [1:0]       cfg_addr;
  logic [31:0]      cfg_din;
  logic [31:0]      cfg_dout;
  logic             interrupter;
  logic             ir_ack;
  logic             ir_ret;
  logic [3:0]       irq_id;
  logic             busy;

  modport slave (
    input  irq_in, cfg_wen, cfg_addr, cfg_din, ir_ack, ir_ret,
    output cfg_dout, interrupter, irq_id, busy
  );

  modport master (
    output irq_in, cfg_wen, cfg_addr, cfg_din, ir_ack, ir_ret,
    input  cfg_dout, interrupter, irq_id, busy
  );
endinterface

// File: rtl/irq_ctrl_sync.sv
// irq_sync: synchroniser for one asynchronous request line.
// SYNC_STAGES flops bring the line into the clk domain. With EDGE=1 an
// extra delay flop after the last stage yields a one-cycle rising-edge
// pulse on hit; with EDGE=0 hit is the synchronised level.
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-low
//   din   raw asynchronous input
//   hit   rising-edge pulse (EDGE=1) or synchronised level (EDGE=0)
module irq_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic hit
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_reg <= '0;
    else      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
  end

  generate
    if (EDGE) begin : g_edge
      logic dly_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) dly_reg <= 1'b0;
        else      dly_reg <= sync_reg[SYNC_STAGES-1];
      end
      assign hit = sync_reg[SYNC_STAGES-1] & ~dly_reg;
    end else begin : g_level
      assign hit = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: external interrupt controller in front of the MIPS core.
// Synchronises N_SRC request lines, keeps edge/level pending state with
// per-source masking, raises interrupter for the lowest-index eligible
// source and holds off further requests until the handler returns.
// Optional build macro IRQ_TIMER_EN adds a compare-match timer as the
// lowest-priority source at index N_SRC.
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-low
//   bus   irq_ctrl_if.slave: irq_in, cfg_wen/addr/din/dout,
//         interrupter, ir_ack, ir_ret, irq_id, busy
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int               N_SRC       = 4,
  parameter logic [N_SRC-1:0] EDGE_MASK   = {N_SRC{1'b1}},
  parameter int               SYNC_STAGES = 2,
  parameter int               TIMER_W     = 32
) (
  input logic       clk,
  input logic       rst,
  irq_ctrl_if.slave bus
);

`ifdef IRQ_TIMER_EN
  localparam int               N_ALL    = N_SRC + 1;
  localparam logic [N_ALL-1:0] EDGE_ALL = {1'b1, EDGE_MASK};
`else
  localparam int               N_ALL    = N_SRC;
  localparam logic [N_ALL-1:0] EDGE_ALL = EDGE_MASK;
`endif

  logic [N_ALL-1:0] src_hit;
  logic [N_ALL-1:0] pend;
  logic [N_ALL-1:0] elig;
  logic [N_ALL-1:0] mask_reg;
  logic [N_ALL-1:0] clr_vec;
  logic [N_ALL-1:0] win_onehot;
  logic [3:0]       winner;
  logic             take;
  logic             wr_mask;
  logic             wr_pend;

  irq_state_e state_reg, state_next;
  logic       interrupter_reg, interrupter_next;
  logic       busy_reg, busy_next;
  logic [3:0] irq_id_reg, irq_id_next;

  // Only the low N_ALL bits (or TIMER_W with the timer) carry data.
  logic din_unused;
  assign din_unused = ^bus.cfg_din[31:N_ALL];

  assign wr_mask = bus.cfg_wen && (bus.cfg_addr == IRQ_ADDR_MASK);
  assign wr_pend = bus.cfg_wen && (bus.cfg_addr == IRQ_ADDR_PEND);

  // External sources: synchronise, then edge pulse or level per EDGE_MASK.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      irq_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE        (EDGE_MASK[gi])
      ) u_sync (
        .clk (clk),
        .rst (rst),
        .din (bus.irq_in[gi]),
        .hit (src_hit[gi])
      );
    end
  endgenerate

`ifdef IRQ_TIMER_EN
  logic [TIMER_W-1:0] tcnt_reg;
  logic [TIMER_W-1:0] tcmp_reg;
  logic               timer_match;
  logic               wr_tcmp;

  assign wr_tcmp     = bus.cfg_wen && (bus.cfg_addr == IRQ_ADDR_TCMP);
  // A zero compare value disables the timer source entirely.
  assign timer_match = (tcmp_reg != '0) && (tcnt_reg == tcmp_reg);
  assign src_hit[N_SRC] = timer_match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_reg <= '0;
      tcmp_reg <= '0;
    end else begin
      tcnt_reg <= timer_match ? '0 : tcnt_reg + TIMER_W'(1);
      if (wr_tcmp) tcmp_reg <= bus.cfg_din[TIMER_W-1:0];
    end
  end
`endif

  // Pending bits: edge sources latch and are cleared by ack/W1C (a new
  // edge in the same cycle wins); level sources simply follow the line.
  generate
    for (genvar gi = 0; gi < N_ALL; gi++) begin : g_pend
      if (EDGE_ALL[gi]) begin : g_edge
        logic p_reg;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) p_reg <= 1'b0;
          else      p_reg <= src_hit[gi] | (p_reg & ~clr_vec[gi]);
        end
        assign pend[gi] = p_reg;
      end else begin : g_level
        logic clr_unused;
        assign clr_unused = clr_vec[gi];
        assign pend[gi]   = src_hit[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         mask_reg <= '0;
    else if (wr_mask) mask_reg <= bus.cfg_din[N_ALL-1:0];
  end

  assign elig       = pend & mask_reg;
  assign winner     = irq_first(16'(elig));
  assign win_onehot = N_ALL'(1) << winner;
  // An ack counts only while something is still eligible this cycle, so a
  // mask/W1C write landing with the ack loses to it.
  assign take       = (state_reg == IRQ_REQ) && bus.ir_ack && (|elig);
  assign clr_vec    = (wr_pend ? bus.cfg_din[N_ALL-1:0] : '0) |
                      (take ? win_onehot : '0);

  // State register plus registered Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IRQ_IDLE;
      interrupter_reg <= 1'b0;
      busy_reg        <= 1'b0;
      irq_id_reg      <= IRQ_ID_NONE;
    end else begin
      state_reg       <= state_next;
      interrupter_reg <= interrupter_next;
      busy_reg        <= busy_next;
      irq_id_reg      <= irq_id_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IRQ_IDLE: if (|elig) state_next = IRQ_REQ;
      IRQ_REQ: begin
        if (take)        state_next = IRQ_SERV;
        else if (~|elig) state_next = IRQ_IDLE;
      end
      IRQ_SERV: if (bus.ir_ret) state_next = IRQ_IDLE;
      default:  state_next = IRQ_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they appear together with it.
  always_comb begin
    interrupter_next = (state_next == IRQ_REQ);
    busy_next        = (state_next == IRQ_SERV);
    irq_id_next      = irq_id_reg;
    if (take)                                        irq_id_next = winner;
    else if ((state_reg == IRQ_SERV) && bus.ir_ret) irq_id_next = IRQ_ID_NONE;
  end

  assign bus.interrupter = interrupter_reg;
  assign bus.busy        = busy_reg;
  assign bus.irq_id      = irq_id_reg;

  always_comb begin
    bus.cfg_dout = '0;
    case (bus.cfg_addr)
      IRQ_ADDR_MASK:  bus.cfg_dout = 32'(mask_reg);
      IRQ_ADDR_PEND:  bus.cfg_dout = 32'(pend);
      IRQ_ADDR_CAUSE: bus.cfg_dout = {28'b0, irq_id_reg};
`ifdef IRQ_TIMER_EN
      IRQ_ADDR_TCMP:  bus.cfg_dout = 32'(tcmp_reg);
`endif
      default:        bus.cfg_dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios with hand-computed checks plus
// a per-cycle comparison against a behavioural model of the controller.
module tb_irq_ctrl;

  localparam int         NS = 4;
  localparam int         S  = 2;
  localparam logic [3:0] EM = 4'b0111;  // source 3 is level-triggered
`ifdef IRQ_TIMER_EN
  localparam int NA = NS + 1;
`else
  localparam int NA = NS;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  bit   done;

  irq_ctrl_if #(.N_SRC(NS)) bus ();

  irq_ctrl #(
    .N_SRC       (NS),
    .EDGE_MASK   (EM),
    .SYNC_STAGES (S),
    .TIMER_W     (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_hist[k] is irq_in as sampled k+1 clock edges ago.
  logic [NS-1:0] m_hist [0:S];
  logic [NA-1:0] m_pe;     // latched edge-type pending
  logic [NA-1:0] m_mask;
  logic          m_req;    // request shown to the core
  logic          m_svc;    // handler running
  logic [3:0]    m_id;
  logic [31:0]   m_cnt;
  logic [31:0]   m_cmp;

  function automatic logic [NA-1:0] m_pending();
    logic [NA-1:0] p;
    p = m_pe;
    for (int i = 0; i < NS; i++) if (!EM[i]) p[i] = m_hist[S-1][i];
    return p;
  endfunction

  function automatic logic [31:0] m_dout(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_mask);
      2'd1:    return 32'(m_pending());
      2'd2:    return {28'b0, m_id};
`ifdef IRQ_TIMER_EN
      default: return m_cmp;
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  task automatic m_reset();
    for (int k = 0; k <= S; k++) m_hist[k] = '0;
    m_pe = '0; m_mask = '0; m_req = 1'b0; m_svc = 1'b0; m_id = 4'hF;
    m_cnt = '0; m_cmp = '0;
  endtask

  task automatic m_step();
    logic [NA-1:0] pend, elig, set_v, clr;
    logic [NS-1:0] rise_v;
    int            win;
    logic          any, take;
    pend   = m_pending();
    elig   = pend & m_mask;
    any    = (elig != '0);
    win    = 15;
    for (int i = NA - 1; i >= 0; i--) if (elig[i]) win = i;
    take   = m_req && bus.ir_ack && any;
    rise_v = m_hist[S-1] & ~m_hist[S];
    set_v  = '0;
    for (int i = 0; i < NS; i++) if (EM[i]) set_v[i] = rise_v[i];
    clr = '0;
    if (bus.cfg_wen && bus.cfg_addr == 2'd1) clr = bus.cfg_din[NA-1:0];
    if (take) clr[win] = 1'b1;
`ifdef IRQ_TIMER_EN
    if (m_cmp != 0 && m_cnt == m_cmp) begin
      set_v[NS] = 1'b1;
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
    if (bus.cfg_wen && bus.cfg_addr == 2'd3) m_cmp = bus.cfg_din;
`endif
    m_pe = set_v | (m_pe & ~clr);
    if (m_svc) begin
      if (bus.ir_ret) begin m_svc = 1'b0; m_id = 4'hF; end
    end else if (m_req) begin
      if (take) begin m_req = 1'b0; m_svc = 1'b1; m_id = 4'(win); end
      else if (!any) m_req = 1'b0;
    end else if (any) begin
      m_req = 1'b1;
    end
    if (bus.cfg_wen && bus.cfg_addr == 2'd0) m_mask = bus.cfg_din[NA-1:0];
    for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = bus.irq_in;
  endtask

  // Per-cycle compare, 1 time unit after each rising edge.
  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!rst) m_reset();
      else      m_step();
      #1;
      if (!done) begin
        check("mon_interrupter", 32'(bus.interrupter), 32'(m_req));
        check("mon_busy",        32'(bus.busy),        32'(m_svc));
        check("mon_irq_id",      32'(bus.irq_id),      32'(m_id));
        check("mon_cfg_dout",    bus.cfg_dout,         m_dout(bus.cfg_addr));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_wen = 1'b1; bus.cfg_addr = a; bus.cfg_din = d;
    step(1);
    bus.cfg_wen = 1'b0; bus.cfg_din = '0;
    $display("cfg write addr=%0d data=%0h", a, d);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.cfg_addr = a;
    #1 d = bus.cfg_dout;
    $display("cfg read  addr=%0d data=%0h", a, d);
  endtask

  task automatic pulse_ack();
    bus.ir_ack = 1'b1; step(1); bus.ir_ack = 1'b0;
    $display("ack  -> irq_id=%0d busy=%0b", bus.irq_id, bus.busy);
  endtask

  task automatic pulse_ret();
    bus.ir_ret = 1'b1; step(1); bus.ir_ret = 1'b0;
    $display("ret  -> irq_id=%0d busy=%0b", bus.irq_id, bus.busy);
  endtask

  task automatic wait_irq(input int bound);
    int k;
    k = 0;
    while (bus.interrupter !== 1'b1 && k < bound) begin
      step(1);
      k++;
    end
    check("wait_interrupter", 32'(bus.interrupter), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int          seen;
    n_vec = 0; n_bad = 0; done = 1'b0;
    rst = 1'b0;
    bus.irq_in = '0; bus.cfg_wen = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_din = '0;
    bus.ir_ack = 1'b0; bus.ir_ret = 1'b0;
    step(3);
    rst = 1'b1;
    check("rst_irq_id", 32'(bus.irq_id), 32'hF);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_interrupter", 32'(bus.interrupter), 32'd0);

    // Edge source 1, exact latency SYNC_STAGES+2 = 4 edges.
    cfg_wr(2'd0, 32'h3);
    bus.irq_in[1] = 1'b1; step(1); bus.irq_in[1] = 1'b0;
    step(2);
    check("lat_minus1", 32'(bus.interrupter), 32'd0);
    step(1);
    check("lat_exact", 32'(bus.interrupter), 32'd1);
    pulse_ack();
    check("t2_id", 32'(bus.irq_id), 32'd1);
    check("t2_busy", 32'(bus.busy), 32'd1);
    check("t2_intr_low", 32'(bus.interrupter), 32'd0);
    rd(2'd1, d); check("t2_pend_cleared", d, 32'h0);
    rd(2'd2, d); check("t2_cause", d, 32'h1);
    step(2);
    pulse_ret();
    check("t2_ret_busy", 32'(bus.busy), 32'd0);
    check("t2_ret_id", 32'(bus.irq_id), 32'hF);
    step(3);
    check("t2_idle", 32'(bus.interrupter), 32'd0);

    // Sources 0 and 2 together: priority, then re-request after return.
    cfg_wr(2'd0, 32'hF);
    bus.irq_in = 4'b0101;
    wait_irq(10);
    pulse_ack();
    check("t3_first_id", 32'(bus.irq_id), 32'd0);
    step(1);
    pulse_ret();
    check("t3_ret_plus1", 32'(bus.interrupter), 32'd0);
    step(1);
    check("t3_ret_plus2", 32'(bus.interrupter), 32'd1);
    pulse_ack();
    check("t3_second_id", 32'(bus.irq_id), 32'd2);
    bus.irq_in = '0;
    pulse_ret();
    step(2);
    check("t3_done", 32'(bus.interrupter), 32'd0);

    // Level source 3 held high.
    bus.irq_in[3] = 1'b1;
    wait_irq(10);
    pulse_ack();
    check("t4_id", 32'(bus.irq_id), 32'd3);
    pulse_ret();
    check("t4_ret_plus1", 32'(bus.interrupter), 32'd0);
    step(1);
    check("t4_rereq", 32'(bus.interrupter), 32'd1);
    cfg_wr(2'd1, 32'h8);
    rd(2'd1, d); check("t4_w1c_level", d, 32'h8);
    check("t4_still_req", 32'(bus.interrupter), 32'd1);
    pulse_ack();
    check("t4_id2", 32'(bus.irq_id), 32'd3);
    bus.irq_in[3] = 1'b0;
    pulse_ret();
    step(4);
    rd(2'd1, d); check("t4_level_gone", d, 32'h0);
    check("t4_idle", 32'(bus.interrupter), 32'd0);

    // Masking while requesting.
    bus.irq_in[1] = 1'b1; step(1); bus.irq_in[1] = 1'b0;
    wait_irq(10);
    cfg_wr(2'd0, 32'h0);
    step(1);
    check("t5_masked", 32'(bus.interrupter), 32'd0);
    rd(2'd1, d); check("t5_pend_kept", d, 32'h2);
    cfg_wr(2'd0, 32'hF);
    step(1);
    check("t5_unmasked", 32'(bus.interrupter), 32'd1);

    // Asynchronous reset in the middle of a request.
    rst = 1'b0;
    #1;
    check("t1_intr", 32'(bus.interrupter), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd0);
    check("t1_id", 32'(bus.irq_id), 32'hF);
    rd(2'd0, d); check("t1_mask", d, 32'h0);
    rd(2'd1, d); check("t1_pend", d, 32'h0);
    step(2);
    rst = 1'b1;

`ifdef IRQ_TIMER_EN
    cfg_wr(2'd3, 32'd10);
    cfg_wr(2'd0, 32'(1 << NS));
    wait_irq(30);
    pulse_ack();
    check("t6_id", 32'(bus.irq_id), 32'(NS));
    pulse_ret();
    cfg_wr(2'd3, 32'd0);
    cfg_wr(2'd1, 32'(1 << NS));
    step(3);
    seen = 0;
    for (int c = 0; c < 1000; c++) begin
      step(1);
      if (bus.interrupter) seen++;
    end
    check("t6_timer_off", 32'(seen), 32'd0);
`else
    seen = 0;
    cfg_wr(2'd3, 32'd10);
    rd(2'd3, d); check("t6_tcmp_reserved", d, 32'h0);
    step(2);
`endif

    step(2);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
